// File: rtl/hz_pkg.sv
// Shared definitions for the hierarchical-Z query path: verdict encodings,
// default field widths, the forwarded record layout and a verdict helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package hz_pkg;

  // 2-bit verdict returned by the HZ tile unit.
  localparam logic [1:0] HZ_REJECT  = 2'b00;
  localparam logic [1:0] HZ_PASS    = 2'b01;
  localparam logic [1:0] HZ_UNKNOWN = 2'b10;
  localparam logic [1:0] HZ_ILLEGAL = 2'b11;

  // Default widths; they must match the HZ unit build.
  localparam int HZ_ADDR_W  = 10;
  localparam int HZ_DEPTH_W = 16;
  localparam int HZ_TAG_W   = 8;

  // Record forwarded to fine raster / early-Z (default-width form).
  typedef struct packed {
    logic [HZ_ADDR_W-1:0] addr;
    logic [HZ_TAG_W-1:0]  tag;
    logic                 need_ztest;
  } hz_rec_t;

  // Anything other than a clean pass still needs a per-sample depth test.
  function automatic logic hz_verdict_needs_ztest(input logic [1:0] v);
    return (v != HZ_PASS);
  endfunction

endpackage

// File: rtl/hz_result_fifo.sv
// Synchronous FIFO holding resolved records until downstream accepts them.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports: clk/rst (sync, active-high); push_i/push_dat_i write port;
//        pop_i read strobe; head_dat_o oldest entry; count_o occupancy.
module hz_result_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/hz_query_issuer.sv
// Issues one HZ min-depth query per coverage record and forwards survivors in order.
// Latency: accept t -> query t+1 -> verdict sampled t+2 -> out_valid t+3 earliest.
// Backpressure: credit based; in_ready drops once FIFO + S1 + S2 fill FIFO_DEPTH.
//
// Ports: in_* coverage record handshake; query_valid/tile_addr/in_depth query
//        to HZ unit; verdict/verdict_valid answer; out_* forwarded record with
//        need_ztest; *_cnt saturating statistics; proto_err sticky; busy.
module hz_query_issuer
  import hz_pkg::*;
#(
  parameter int ADDR_WIDTH = HZ_ADDR_W,
  parameter int DEPTH_W    = HZ_DEPTH_W,
  parameter int TAG_W      = HZ_TAG_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DEPTH_W-1:0]    in_zmin,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  query_valid,
  output logic [ADDR_WIDTH-1:0] tile_addr,
  output logic [DEPTH_W-1:0]    in_depth,
  input  logic [1:0]            verdict,
  input  logic                  verdict_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_need_ztest,
  output logic [CNT_W-1:0]      rejected_cnt,
  output logic [CNT_W-1:0]      passed_cnt,
  output logic [CNT_W-1:0]      unknown_cnt,
  output logic                  proto_err,
  output logic                  busy
);

  // Same layout as hz_rec_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [TAG_W-1:0]      tag;
    logic                  need_ztest;
  } rec_t;

  localparam int REC_W = $bits(rec_t);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  // S1: query register.
  logic                  s1_v_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DEPTH_W-1:0]    s1_zmin_q;
  logic [TAG_W-1:0]      s1_tag_q;
  // S2: awaiting verdict.
  logic                  s2_v_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic [TAG_W-1:0]      s2_tag_q;
  // High in the first cycle after reset, to ignore a late verdict.
  logic                  rst_seen_q;

  logic [CNT_W-1:0] rejected_cnt_q, passed_cnt_q, unknown_cnt_q;
  logic [CNT_W-1:0] rejected_cnt_d, passed_cnt_d, unknown_cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             s1_v_d;

  logic          accept;
  logic          push, pop;
  rec_t          push_rec, head_rec;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          inc_rej, inc_pass, inc_unk, err_set;

  hz_result_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_rec),
    .pop_i      (pop),
    .head_dat_o (head_rec),
    .count_o    (fifo_count)
  );

  // Every record in S1/S2 may still need a FIFO slot, so it holds a credit.
  // Registers only: a pop this cycle does not return a credit until next cycle.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_v_q} + {{CW{1'b0}}, s2_v_q};
  assign in_ready  = (occupancy < CREDITS) && !rst;
  assign accept    = in_valid && in_ready;

  assign query_valid = s1_v_q;
  assign tile_addr   = s1_addr_q;
  assign in_depth    = s1_zmin_q;

  assign out_valid      = (fifo_count != '0);
  assign pop            = out_valid && out_ready;
  // Gated so the output bus reads zero whenever nothing is offered.
  assign out_addr       = out_valid ? head_rec.addr       : '0;
  assign out_tag        = out_valid ? head_rec.tag        : '0;
  assign out_need_ztest = out_valid ? head_rec.need_ztest : 1'b0;

  assign rejected_cnt = rejected_cnt_q;
  assign passed_cnt   = passed_cnt_q;
  assign unknown_cnt  = unknown_cnt_q;
  assign proto_err    = proto_err_q;
  assign busy         = s1_v_q | s2_v_q | out_valid;

  // S2 resolution and next-state for statistics / error.
  always_comb begin
    push     = 1'b0;
    push_rec = '{addr: s2_addr_q, tag: s2_tag_q, need_ztest: 1'b1};
    inc_rej  = 1'b0;
    inc_pass = 1'b0;
    inc_unk  = 1'b0;
    err_set  = 1'b0;
    s1_v_d   = accept;

    if (s2_v_q) begin
      if (!verdict_valid) begin
        // Missing answer: forward conservatively and flag the unit.
        push    = 1'b1;
        inc_unk = 1'b1;
        err_set = 1'b1;
      end else if (verdict == HZ_REJECT) begin
        inc_rej = 1'b1;
      end else begin
        push                = 1'b1;
        push_rec.need_ztest = hz_verdict_needs_ztest(verdict);
        inc_pass            = (verdict == HZ_PASS);
        inc_unk             = (verdict != HZ_PASS);
        err_set             = (verdict == HZ_ILLEGAL);
      end
    end else if (verdict_valid && !rst_seen_q) begin
      // Stray verdict with nothing outstanding.
      err_set = 1'b1;
    end

    rejected_cnt_d = rejected_cnt_q;
    passed_cnt_d   = passed_cnt_q;
    unknown_cnt_d  = unknown_cnt_q;
    if (inc_rej  && (rejected_cnt_q != '1)) rejected_cnt_d = rejected_cnt_q + CNT_W'(1);
    if (inc_pass && (passed_cnt_q   != '1)) passed_cnt_d   = passed_cnt_q   + CNT_W'(1);
    if (inc_unk  && (unknown_cnt_q  != '1)) unknown_cnt_d  = unknown_cnt_q  + CNT_W'(1);
    proto_err_d = proto_err_q | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q         <= 1'b0;
      s1_addr_q      <= '0;
      s1_zmin_q      <= '0;
      s1_tag_q       <= '0;
      s2_v_q         <= 1'b0;
      s2_addr_q      <= '0;
      s2_tag_q       <= '0;
      rst_seen_q     <= 1'b1;
      rejected_cnt_q <= '0;
      passed_cnt_q   <= '0;
      unknown_cnt_q  <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (accept) begin
        s1_addr_q <= in_addr;
        s1_zmin_q <= in_zmin;
        s1_tag_q  <= in_tag;
      end
      // The HZ unit answers in a fixed cycle, so S1 never stalls into S2.
      s2_v_q         <= s1_v_q;
      s2_addr_q      <= s1_addr_q;
      s2_tag_q       <= s1_tag_q;
      rst_seen_q     <= 1'b0;
      rejected_cnt_q <= rejected_cnt_d;
      passed_cnt_q   <= passed_cnt_d;
      unknown_cnt_q  <= unknown_cnt_d;
      proto_err_q    <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_hz_query_issuer.sv
module tb_hz_query_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [9:0]  in_addr;
  logic [15:0] in_zmin;
  logic [7:0]  in_tag;
  logic        query_valid;
  logic [9:0]  tile_addr;
  logic [15:0] in_depth;
  logic [1:0]  verdict;
  logic        verdict_valid;
  logic        out_valid, out_ready;
  logic [9:0]  out_addr;
  logic [7:0]  out_tag;
  logic        out_need_ztest;
  logic [31:0] rejected_cnt, passed_cnt, unknown_cnt;
  logic        proto_err, busy;

  always #5 clk = ~clk;

  hz_query_issuer #(
    .ADDR_WIDTH (10), .DEPTH_W (16), .TAG_W (8), .FIFO_DEPTH (4), .CNT_W (32)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_addr (in_addr), .in_zmin (in_zmin), .in_tag (in_tag),
    .query_valid (query_valid), .tile_addr (tile_addr), .in_depth (in_depth),
    .verdict (verdict), .verdict_valid (verdict_valid),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_addr (out_addr), .out_tag (out_tag), .out_need_ztest (out_need_ztest),
    .rejected_cnt (rejected_cnt), .passed_cnt (passed_cnt), .unknown_cnt (unknown_cnt),
    .proto_err (proto_err), .busy (busy)
  );

  typedef struct { logic [9:0] addr; logic [15:0] zmin; } exp_q_t;
  typedef struct { logic [9:0] addr; logic [7:0] tag; logic need; } exp_o_t;

  int     n_vec = 0;
  int     n_err = 0;
  exp_q_t q_exp[$];
  exp_o_t o_exp[$];
  int     plan_q[$];   // per record: -1 omit verdict_valid, else verdict value
  int     cur_plan = 1;
  bit     qv_seen = 1'b0;
  bit     stub_en = 1'b1;
  int     n_acc = 0;
  exp_q_t eq;
  exp_o_t eo;
  int     sp;

  // Scoreboard: push expectations at acceptance, compare on query/output.
  always @(negedge clk) begin
    qv_seen = 1'b0;
    if (!rst) begin
      if (query_valid) begin
        qv_seen = 1'b1;
        n_vec++;
        if (q_exp.size() == 0) begin
          n_err++;
          $display("FAIL query_unexpected: tile_addr=%0d, no record outstanding", tile_addr);
        end else begin
          eq = q_exp.pop_front();
          if (tile_addr !== eq.addr || in_depth !== eq.zmin) begin
            n_err++;
            $display("FAIL query_fields: got addr=%0d depth=%0d, want addr=%0d depth=%0d",
                     tile_addr, in_depth, eq.addr, eq.zmin);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (o_exp.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: addr=%0d tag=%0d need=%0d", out_addr, out_tag, out_need_ztest);
        end else begin
          eo = o_exp.pop_front();
          if (out_addr !== eo.addr || out_tag !== eo.tag || out_need_ztest !== eo.need) begin
            n_err++;
            $display("FAIL out_fields: got addr=%0d tag=%0d need=%0d, want addr=%0d tag=%0d need=%0d",
                     out_addr, out_tag, out_need_ztest, eo.addr, eo.tag, eo.need);
          end
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        q_exp.push_back('{addr: in_addr, zmin: in_zmin});
        plan_q.push_back(cur_plan);
        if (cur_plan != 0) o_exp.push_back('{addr: in_addr, tag: in_tag, need: (cur_plan != 1)});
      end
    end
  end

  // HZ unit stub: answer one cycle after the query is seen.
  always @(posedge clk) begin
    #1;
    if (stub_en) begin
      verdict_valid = 1'b0;
      verdict       = 2'b00;
      if (qv_seen && plan_q.size() > 0) begin
        sp = plan_q.pop_front();
        if (sp >= 0) begin
          verdict_valid = 1'b1;
          verdict       = sp[1:0];
        end
      end
    end
  end

  task automatic clear_sb();
    q_exp.delete();
    o_exp.delete();
    plan_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_sb();
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] a, input logic [15:0] z, input logic [7:0] t,
                      input int plan, output int stalls);
    stalls   = 0;
    in_addr  = a;
    in_zmin  = z;
    in_tag   = t;
    cur_plan = plan;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready=%0d after %0d cycles, want 1", in_ready, stalls);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int st;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) send(10'(40 + i), 16'(i), 8'(i), 1, st);
    wait_cycles(4);
    // Assert reset mid-operation with a record being offered.
    in_addr = 10'd99; in_tag = 8'd99; in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0d want 0", in_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if ({query_valid, out_valid, out_addr, out_tag, out_need_ztest, proto_err, busy, in_ready} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: qv=%0d ov=%0d oa=%0d ot=%0d nz=%0d pe=%0d busy=%0d rdy=%0d, want all 0",
                 query_valid, out_valid, out_addr, out_tag, out_need_ztest, proto_err, busy, in_ready);
      end
      n_vec++;
      if (rejected_cnt !== 0 || passed_cnt !== 0 || unknown_cnt !== 0) begin
        n_err++;
        $display("FAIL reset_counters: rej=%0d pass=%0d unk=%0d want 0/0/0", rejected_cnt, passed_cnt, unknown_cnt);
      end
    end
    // Release with a late verdict arriving in the first post-reset cycle.
    @(posedge clk);
    #1;
    clear_sb();
    in_valid = 1'b0;
    stub_en = 1'b0;
    verdict_valid = 1'b1;
    verdict = 2'b11;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%0d busy=%0d want 1/0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    verdict_valid = 1'b0;
    stub_en = 1'b1;
    wait_cycles(2);
    n_vec++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_late_verdict: proto_err=%0d want 0", proto_err); end
  endtask

  task automatic test_reject();
    int st;
    bit saw;
    out_ready = 1'b1;
    do_reset();
    send(10'd5, 16'd100, 8'd3, 0, st);
    @(negedge clk);   // cycle t+1
    n_vec++;
    if (query_valid !== 1'b1 || tile_addr !== 10'd5 || in_depth !== 16'd100) begin
      n_err++;
      $display("FAIL reject_query_t1: qv=%0d addr=%0d depth=%0d want 1/5/100", query_valid, tile_addr, in_depth);
    end
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (out_valid) saw = 1'b1; end
    n_vec++;
    if (saw !== 1'b0) begin n_err++; $display("FAIL reject_no_output: out_valid seen=%0d want 0", saw); end
    n_vec++;
    if (rejected_cnt !== 32'd1 || passed_cnt !== 0 || unknown_cnt !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reject_counts: rej=%0d pass=%0d unk=%0d busy=%0d want 1/0/0/0",
               rejected_cnt, passed_cnt, unknown_cnt, busy);
    end
  endtask

  task automatic test_pass_unknown();
    int st, first;
    logic [9:0] a;
    logic [7:0] t;
    logic nz;
    for (int p = 1; p <= 2; p++) begin
      out_ready = 1'b1;
      do_reset();
      send(10'd5, 16'd100, 8'd3, p, st);
      first = -1;
      a = '0; t = '0; nz = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (out_valid && first < 0) begin first = k; a = out_addr; t = out_tag; nz = out_need_ztest; end
      end
      n_vec++;
      if (first != 3 || a !== 10'd5 || t !== 8'd3 || nz !== (p == 2)) begin
        n_err++;
        $display("FAIL pass_unknown_%0d: latency=%0d addr=%0d tag=%0d need=%0d want 3/5/3/%0d",
                 p, first, a, t, nz, (p == 2));
      end
      n_vec++;
      if (passed_cnt !== 32'(p == 1) || unknown_cnt !== 32'(p == 2) || proto_err !== 1'b0) begin
        n_err++;
        $display("FAIL pass_unknown_cnt_%0d: pass=%0d unk=%0d pe=%0d want %0d/%0d/0",
                 p, passed_cnt, unknown_cnt, proto_err, (p == 1), (p == 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int  tag;
    bit  acc;
    out_ready = 1'b0;
    do_reset();
    tag = 0;
    cur_plan = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (tag < 6);
      in_addr = 10'(20 + tag); in_zmin = 16'(tag * 11); in_tag = 8'(tag);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) tag++;
    end
    @(negedge clk);
    n_vec++;
    if (tag != 4 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credit_limit: accepted=%0d in_ready=%0d want 4/0", tag, in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_tag !== 8'd0 || out_addr !== 10'd20) begin
      n_err++;
      $display("FAIL bp_head_hold: ov=%0d tag=%0d addr=%0d want 1/0/20", out_valid, out_tag, out_addr);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && tag < 6; c++) begin
      in_valid = 1'b1;
      in_addr = 10'(20 + tag); in_zmin = 16'(tag * 11); in_tag = 8'(tag);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) tag++;
    end
    in_valid = 1'b0;
    wait_cycles(8);
    n_vec++;
    if (tag != 6 || o_exp.size() != 0 || passed_cnt !== 32'd6) begin
      n_err++;
      $display("FAIL bp_drain: accepted=%0d pending=%0d passed=%0d want 6/0/6", tag, o_exp.size(), passed_cnt);
    end
  endtask

  task automatic test_proto_fault();
    int st;
    out_ready = 1'b1;
    do_reset();
    send(10'd7, 16'd50, 8'd9, -1, st);
    wait_cycles(5);
    n_vec++;
    if (proto_err !== 1'b1 || unknown_cnt !== 32'd1 || o_exp.size() != 0) begin
      n_err++;
      $display("FAIL proto_missing_verdict: pe=%0d unk=%0d pending=%0d want 1/1/0",
               proto_err, unknown_cnt, o_exp.size());
    end
    send(10'd8, 16'd60, 8'd1, 1, st);
    wait_cycles(5);
    n_vec++;
    if (proto_err !== 1'b1 || passed_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL proto_sticky: pe=%0d pass=%0d want 1/1", proto_err, passed_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int st, stalls, acc0;
    out_ready = 1'b1;
    do_reset();
    stalls = 0;
    acc0 = n_acc;
    for (int i = 0; i < 99; i++) begin
      send(10'(i), 16'(i * 7), 8'(i), i % 3, st);
      stalls += st;
    end
    wait_cycles(8);
    n_vec++;
    if (stalls != 0 || (n_acc - acc0) != 99) begin
      n_err++;
      $display("FAIL stream_rate: stalls=%0d accepted=%0d want 0/99", stalls, n_acc - acc0);
    end
    n_vec++;
    if (rejected_cnt !== 32'd33 || passed_cnt !== 32'd33 || unknown_cnt !== 32'd33) begin
      n_err++;
      $display("FAIL stream_counts: rej=%0d pass=%0d unk=%0d want 33/33/33", rejected_cnt, passed_cnt, unknown_cnt);
    end
    n_vec++;
    if (o_exp.size() != 0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL stream_drain: pending=%0d busy=%0d pe=%0d want 0/0/0", o_exp.size(), busy, proto_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_zmin = '0;
    in_tag = '0;
    out_ready = 1'b0;
    verdict = 2'b00;
    verdict_valid = 1'b0;
    test_reset();
    test_reject();
    test_pass_unknown();
    test_backpressure();
    test_proto_fault();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
